control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main instruction decoder for the single-issue MIPS core; sits between instruction fetch and the register file, ALU and memory datapath.
- Combines opcode decoding (datapath/memory/branch controls) with funct decoding (4-bit ALU operation, shift/jr/syscall flags).
- All outputs are registered: decode of op/funct sampled at a rising clock edge appears on the outputs after that edge.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  6  instruction[31:26]
- funct  input  6  instruction[5:0]
- RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst  output  1 each  datapath controls
- Branch, BneOrBeq, Jump, IsJAL, IsJR  output  1 each  PC-control flags
- IsSyscall, IsShamt, ZeroExtend, ReadRs, ReadRt, IsCOP0  output  1 each  misc flags
- ALUop  output  4  ALU operation select

Behaviour:
- Reset: while rst_n=0, every output is 0, including ALUop=0000. Reset is asynchronous on assertion. The first decode is captured at the first rising edge after release.
- Latency: exactly 1 cycle. Outputs update on every rising edge; there is no enable or handshake.
- R-type (op=0x00), decoded by funct:
  - add 0x20, addu 0x21 -> ALUop 5
  - sub 0x22 -> 6
  - and 0x24 -> 7
  - or 0x25 -> 8
  - xor 0x26 -> 9
  - nor 0x27 -> 10
  - slt 0x2A -> 11
  - sltu 0x2B -> 12
  - sll 0x00, sllv 0x04 -> 0
  - sra 0x03, srav 0x07 -> 1
  - srl 0x02, srlv 0x06 -> 2
- These R-type ALU ops set RegWrite=1, RegDst=1, ReadRt=1. ReadRs=1 except for sll, srl and sra, which instead set IsShamt=1.
- jr (funct 0x08): IsJR=1, Jump=1, ReadRs=1, ALUop=5.
- syscall (funct 0x0C): IsSyscall=1, ALUop=5, all other outputs 0.
- I-type and J-type (op≠0), decoded by op; funct is ignored, so outputs must not change for any funct value, including X:
  - addi 0x08, addiu 0x09: ALUop 5, RegWrite, ALUSrc, ReadRs
  - slti 0x0A: ALUop 11, RegWrite, ALUSrc, ReadRs
  - sltiu 0x0B: ALUop 12, RegWrite, ALUSrc, ReadRs
  - andi 0x0C, ori 0x0D, xori 0x0E: ALUop 7/8/9, RegWrite, ALUSrc, ReadRs, ZeroExtend
  - lw 0x23: ALUop 5, RegWrite, ALUSrc, MemRead, MemtoReg, ReadRs
  - sw 0x2B: ALUop 5, ALUSrc, MemWrite, ReadRs, ReadRt
  - beq 0x04: ALUop 6, Branch, ReadRs, ReadRt, BneOrBeq=0
  - bne 0x05: same as beq but BneOrBeq=1
  - j 0x02: Jump
  - jal 0x03: Jump, IsJAL, RegWrite (write to $31)
- COP0 (op=0x10): IsCOP0=1 for every funct; all other outputs 0, ALUop=5.
- Unlisted op or unlisted R-type funct: all flags 0, ALUop=5 (a safe NOP).
- Any flag not listed for an instruction is 0.

Optional Feature:
- Macro CTRL_COP0_EN.
- Defined: IsCOP0 decoded as above.
- Undefined: IsCOP0 is tied to 0, and op=0x10 decodes as an unlisted opcode (all flags 0, ALUop=5).

Test Plan:
- Reset: rst_n=0 with op=0x23 applied mid-cycle -> all outputs 0 immediately. Release rst_n, one edge -> lw decode: RegWrite=MemRead=MemtoReg=ALUSrc=ReadRs=1, ALUop=0101.
- R-type: op=0, funct=0x20 -> RegWrite=RegDst=ReadRs=ReadRt=1, ALUop=0101. funct=0x22 -> ALUop=0110. funct=0x00 -> IsShamt=1, ReadRs=0, ALUop=0000.
- Special R-type: funct=0x08 -> IsJR=Jump=ReadRs=1, RegWrite=0. funct=0x0C -> IsSyscall=1, all other flags 0.
- I-type with funct=X: addi -> ALUSrc=RegWrite=1, ALUop=0101. sw -> MemWrite=1, RegWrite=0. beq -> Branch=1, BneOrBeq=0, ALUop=0110. bne -> BneOrBeq=1. No output is X in any of these cases.
- Jumps: op=0x02 -> Jump=1, IsJAL=0. op=0x03 -> Jump=IsJAL=RegWrite=1.
- COP0 (macro defined): op=0x10 with funct=0x00, then funct=0x18 -> IsCOP0=1, all other flags 0. With the macro undefined -> IsCOP0=0.

Source files
------------

// File: rtl/control_unit_if.sv
// Decode bus between instruction fetch and the control unit.
// Carries the op/funct fields in and every registered control flag out.
interface control_unit_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       RegWrite;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       ALUSrc;
   logic       RegDst;
   logic       Branch;
   logic       BneOrBeq;
   logic       Jump;
   logic       IsJAL;
   logic       IsJR;
   logic       IsSyscall;
   logic       IsShamt;
   logic       ZeroExtend;
   logic       ReadRs;
   logic       ReadRt;
   logic       IsCOP0;
   logic [3:0] ALUop;

   // Handshake: none. op/funct are sampled on every rising edge and the
   // decoded controls are valid from that edge until the next one.
   modport master (
      output op, funct,
      input  RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst,
      input  Branch, BneOrBeq, Jump, IsJAL, IsJR,
      input  IsSyscall, IsShamt, ZeroExtend, ReadRs, ReadRt, IsCOP0, ALUop
   );

   modport slave (
      input  op, funct,
      output RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst,
      output Branch, BneOrBeq, Jump, IsJAL, IsJR,
      output IsSyscall, IsShamt, ZeroExtend, ReadRs, ReadRt, IsCOP0, ALUop
   );
endinterface

// File: rtl/control_unit.sv
// Registered MIPS main decoder: op/funct -> datapath, PC and ALU controls.
// Optional COP0 decode (op=0x10) is enabled by defining CTRL_COP0_EN.
module control_unit (
   input  logic         clk,
   input  logic         rst_n,
   control_unit_if.slave bus
);

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic       reg_dst;
      logic       branch;
      logic       bne_or_beq;
      logic       jump;
      logic       is_jal;
      logic       is_jr;
      logic       is_syscall;
      logic       is_shamt;
      logic       zero_extend;
      logic       read_rs;
      logic       read_rt;
      logic       is_cop0;
      logic [3:0] alu_op;
   } ctrl_t;

   localparam logic [3:0] ALU_SLL  = 4'd0;
   localparam logic [3:0] ALU_SRA  = 4'd1;
   localparam logic [3:0] ALU_SRL  = 4'd2;
   localparam logic [3:0] ALU_ADD  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;
   localparam logic [3:0] ALU_NOR  = 4'd10;
   localparam logic [3:0] ALU_SLT  = 4'd11;
   localparam logic [3:0] ALU_SLTU = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_COP0  = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   ctrl_t      w_rtype;
   ctrl_t      w_itype;
   ctrl_t      w_next;
   ctrl_t      r_ctrl;
   logic       w_r_alu;
   logic       w_r_imm_shift;
   logic [3:0] w_r_alu_op;

   // funct-field decode: which R-type ALU op, and whether it is a shamt shift.
   always_comb begin
      w_r_alu       = 1'b0;
      w_r_imm_shift = 1'b0;
      w_r_alu_op    = ALU_ADD;
      case (bus.funct)
         6'h20, 6'h21: begin w_r_alu = 1'b1; w_r_alu_op = ALU_ADD;  end
         6'h22:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SUB;  end
         6'h24:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_AND;  end
         6'h25:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_OR;   end
         6'h26:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_XOR;  end
         6'h27:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_NOR;  end
         6'h2A:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SLT;  end
         6'h2B:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SLTU; end
         6'h00: begin w_r_alu = 1'b1; w_r_imm_shift = 1'b1; w_r_alu_op = ALU_SLL; end
         6'h03: begin w_r_alu = 1'b1; w_r_imm_shift = 1'b1; w_r_alu_op = ALU_SRA; end
         6'h02: begin w_r_alu = 1'b1; w_r_imm_shift = 1'b1; w_r_alu_op = ALU_SRL; end
         6'h04:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SLL;  end
         6'h07:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SRA;  end
         6'h06:        begin w_r_alu = 1'b1; w_r_alu_op = ALU_SRL;  end
         default: begin
            w_r_alu       = 1'b0;
            w_r_imm_shift = 1'b0;
            w_r_alu_op    = ALU_ADD;
         end
      endcase
   end

   always_comb begin
      w_rtype        = '0;
      w_rtype.alu_op = ALU_ADD;
      if (w_r_alu) begin
         w_rtype.alu_op    = w_r_alu_op;
         w_rtype.reg_write = 1'b1;
         w_rtype.reg_dst   = 1'b1;
         w_rtype.read_rt   = 1'b1;
         w_rtype.read_rs   = ~w_r_imm_shift;
         w_rtype.is_shamt  = w_r_imm_shift;
      end else if (bus.funct == 6'h08) begin
         w_rtype.is_jr   = 1'b1;
         w_rtype.jump    = 1'b1;
         w_rtype.read_rs = 1'b1;
      end else if (bus.funct == 6'h0C) begin
         w_rtype.is_syscall = 1'b1;
      end
   end

   // op-field decode; funct is never referenced here so an X funct cannot leak.
   always_comb begin
      w_itype        = '0;
      w_itype.alu_op = ALU_ADD;
      case (bus.op)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
            w_itype.reg_write = 1'b1;
            w_itype.alu_src   = 1'b1;
            w_itype.read_rs   = 1'b1;
            if (bus.op == OP_SLTI)       w_itype.alu_op = ALU_SLT;
            else if (bus.op == OP_SLTIU) w_itype.alu_op = ALU_SLTU;
            else                         w_itype.alu_op = ALU_ADD;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            w_itype.reg_write   = 1'b1;
            w_itype.alu_src     = 1'b1;
            w_itype.read_rs     = 1'b1;
            w_itype.zero_extend = 1'b1;
            if (bus.op == OP_ANDI)     w_itype.alu_op = ALU_AND;
            else if (bus.op == OP_ORI) w_itype.alu_op = ALU_OR;
            else                       w_itype.alu_op = ALU_XOR;
         end
         OP_LW: begin
            w_itype.reg_write  = 1'b1;
            w_itype.alu_src    = 1'b1;
            w_itype.mem_read   = 1'b1;
            w_itype.mem_to_reg = 1'b1;
            w_itype.read_rs    = 1'b1;
         end
         OP_SW: begin
            w_itype.alu_src   = 1'b1;
            w_itype.mem_write = 1'b1;
            w_itype.read_rs   = 1'b1;
            w_itype.read_rt   = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_itype.alu_op     = ALU_SUB;
            w_itype.branch     = 1'b1;
            w_itype.read_rs    = 1'b1;
            w_itype.read_rt    = 1'b1;
            w_itype.bne_or_beq = (bus.op == OP_BNE);
         end
         OP_J: begin
            w_itype.jump = 1'b1;
         end
         OP_JAL: begin
            w_itype.jump      = 1'b1;
            w_itype.is_jal    = 1'b1;
            w_itype.reg_write = 1'b1;
         end
`ifdef CTRL_COP0_EN
         OP_COP0: begin
            w_itype.is_cop0 = 1'b1;
         end
`endif
         default: begin
            w_itype        = '0;
            w_itype.alu_op = ALU_ADD;
         end
      endcase
   end

   assign w_next = (bus.op == OP_RTYPE) ? w_rtype : w_itype;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ctrl <= '0;
      else        r_ctrl <= w_next;
   end

   assign bus.RegWrite   = r_ctrl.reg_write;
   assign bus.MemRead    = r_ctrl.mem_read;
   assign bus.MemWrite   = r_ctrl.mem_write;
   assign bus.MemtoReg   = r_ctrl.mem_to_reg;
   assign bus.ALUSrc     = r_ctrl.alu_src;
   assign bus.RegDst     = r_ctrl.reg_dst;
   assign bus.Branch     = r_ctrl.branch;
   assign bus.BneOrBeq   = r_ctrl.bne_or_beq;
   assign bus.Jump       = r_ctrl.jump;
   assign bus.IsJAL      = r_ctrl.is_jal;
   assign bus.IsJR       = r_ctrl.is_jr;
   assign bus.IsSyscall  = r_ctrl.is_syscall;
   assign bus.IsShamt    = r_ctrl.is_shamt;
   assign bus.ZeroExtend = r_ctrl.zero_extend;
   assign bus.ReadRs     = r_ctrl.read_rs;
   assign bus.ReadRt     = r_ctrl.read_rt;
   assign bus.IsCOP0     = r_ctrl.is_cop0;
   assign bus.ALUop      = r_ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level decode model plus scoreboard,
// with directed vectors and literal expectations for key instructions.
module tb_control_unit;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [20:0] exp_q[$];

   control_unit_if cu_if ();

   control_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (cu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag masks in output-vector order; ALUop occupies bits [3:0].
   localparam logic [20:0] F_RW   = 21'h100000;
   localparam logic [20:0] F_MR   = 21'h080000;
   localparam logic [20:0] F_MW   = 21'h040000;
   localparam logic [20:0] F_M2R  = 21'h020000;
   localparam logic [20:0] F_ASRC = 21'h010000;
   localparam logic [20:0] F_RDST = 21'h008000;
   localparam logic [20:0] F_BR   = 21'h004000;
   localparam logic [20:0] F_BNE  = 21'h002000;
   localparam logic [20:0] F_JMP  = 21'h001000;
   localparam logic [20:0] F_JAL  = 21'h000800;
   localparam logic [20:0] F_JR   = 21'h000400;
   localparam logic [20:0] F_SYS  = 21'h000200;
   localparam logic [20:0] F_SH   = 21'h000100;
   localparam logic [20:0] F_ZE   = 21'h000080;
   localparam logic [20:0] F_RS   = 21'h000040;
   localparam logic [20:0] F_RT   = 21'h000020;
   localparam logic [20:0] F_COP  = 21'h000010;

   function automatic logic [20:0] dut_vec();
      return {cu_if.RegWrite, cu_if.MemRead, cu_if.MemWrite, cu_if.MemtoReg,
              cu_if.ALUSrc, cu_if.RegDst, cu_if.Branch, cu_if.BneOrBeq,
              cu_if.Jump, cu_if.IsJAL, cu_if.IsJR, cu_if.IsSyscall,
              cu_if.IsShamt, cu_if.ZeroExtend, cu_if.ReadRs, cu_if.ReadRt,
              cu_if.IsCOP0, cu_if.ALUop};
   endfunction

   // Instruction-class model: arithmetic on field values, not a case table.
   function automatic logic [20:0] model(input logic [5:0] op, input logic [5:0] f);
      logic [20:0] v;
      int          fi;
      int          oi;
      v  = 21'd5;
      fi = int'(f);
      oi = int'(op);
      if (oi == 0) begin
         if ((fi >= 'h20 && fi <= 'h22) || (fi >= 'h24 && fi <= 'h27) ||
             fi == 'h2A || fi == 'h2B || fi == 0 || fi == 2 || fi == 3 ||
             fi == 4 || fi == 6 || fi == 7) begin
            v = F_RW | F_RDST | F_RT;
            if (fi < 8) begin
               // shift family: low two bits 0->sll, 3->sra, 2->srl
               v[3:0] = (fi % 4 == 0) ? 4'd0 : (fi % 4 == 3) ? 4'd1 : 4'd2;
               if (fi < 4) v = v | F_SH;
               else        v = v | F_RS;
            end else begin
               v = v | F_RS;
               if (fi <= 'h21)      v[3:0] = 4'd5;
               else if (fi == 'h22) v[3:0] = 4'd6;
               else if (fi <= 'h27) v[3:0] = 4'(fi - 'h24 + 7);
               else                 v[3:0] = 4'(fi - 'h2A + 11);
            end
         end else if (fi == 'h08) v = F_JR | F_JMP | F_RS | 21'd5;
         else if (fi == 'h0C) v = F_SYS | 21'd5;
      end else if (oi >= 'h08 && oi <= 'h0B) begin
         v = F_RW | F_ASRC | F_RS | ((oi <= 'h09) ? 21'd5 : 21'(oi - 'h0A + 11));
      end else if (oi >= 'h0C && oi <= 'h0E) begin
         v = F_RW | F_ASRC | F_RS | F_ZE | 21'(oi - 'h0C + 7);
      end else if (oi == 'h23) v = F_RW | F_ASRC | F_MR | F_M2R | F_RS | 21'd5;
      else if (oi == 'h2B) v = F_ASRC | F_MW | F_RS | F_RT | 21'd5;
      else if (oi == 4 || oi == 5) begin
         v = F_BR | F_RS | F_RT | 21'd6;
         if (oi == 5) v = v | F_BNE;
      end else if (oi == 2) v = F_JMP | 21'd5;
      else if (oi == 3) v = F_JMP | F_JAL | F_RW | 21'd5;
`ifdef CTRL_COP0_EN
      else if (oi == 'h10) v = F_COP | 21'd5;
`endif
      return v;
   endfunction

   task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%06h want=%06h", name, got, exp);
      end
   endtask

   // Scoreboard: capture expectation at each sampling edge, compare mid-cycle.
   always @(posedge clk) begin
      if (rst_n) exp_q.push_back(model(cu_if.op, cu_if.funct));
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_hold", dut_vec(), 21'd0);
      end else if (exp_q.size() > 0) begin
         check("scoreboard", dut_vec(), exp_q.pop_front());
      end
   end

   task automatic step(input logic [5:0] op, input logic [5:0] f);
      @(negedge clk);
      cu_if.op    = op;
      cu_if.funct = f;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [5:0] op, input logic [5:0] f,
                      input logic [20:0] exp);
      logic [20:0] got;
      step(op, f);
      got = dut_vec();
      check(name, got, exp);
      total++;
      if ($isunknown(got)) begin
         bad++;
         $display("FAIL %s_known: got=%06h want=no X", name, got);
      end
   endtask

   logic [11:0] vecs [0:27];

   initial begin
      vecs = '{ {6'h00,6'h21}, {6'h00,6'h24}, {6'h00,6'h25}, {6'h00,6'h26},
                {6'h00,6'h27}, {6'h00,6'h2A}, {6'h00,6'h2B}, {6'h00,6'h02},
                {6'h00,6'h03}, {6'h00,6'h04}, {6'h00,6'h06}, {6'h00,6'h07},
                {6'h00,6'h01}, {6'h00,6'h3F}, {6'h09,6'h15}, {6'h0A,6'h2B},
                {6'h0B,6'h08}, {6'h0C,6'h0C}, {6'h0D,6'h00}, {6'h0E,6'h3F},
                {6'h23,6'h20}, {6'h2B,6'h00}, {6'h10,6'h08}, {6'h3F,6'h20},
                {6'h01,6'h00}, {6'h11,6'h0C}, {6'h02,6'h2A}, {6'h05,6'h21} };
      total       = 0;
      bad         = 0;
      rst_n       = 1'b1;
      cu_if.op    = 6'h00;
      cu_if.funct = 6'h00;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step(6'h00, 6'h20);
      step(6'h0D, 6'h00);

      // asynchronous reset assertion mid-cycle
      @(negedge clk);
      #2;
      rst_n       = 1'b0;
      cu_if.op    = 6'h23;
      cu_if.funct = 6'h00;
      #1;
      check("reset_async", dut_vec(), 21'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("lw_after_reset", dut_vec(), F_RW | F_MR | F_M2R | F_ASRC | F_RS | 21'd5);

      lit("add",     6'h00, 6'h20, F_RW | F_RDST | F_RS | F_RT | 21'd5);
      lit("sub",     6'h00, 6'h22, F_RW | F_RDST | F_RS | F_RT | 21'd6);
      lit("sll",     6'h00, 6'h00, F_RW | F_RDST | F_SH | F_RT | 21'd0);
      lit("srav",    6'h00, 6'h07, F_RW | F_RDST | F_RS | F_RT | 21'd1);
      lit("jr",      6'h00, 6'h08, F_JR | F_JMP | F_RS | 21'd5);
      lit("syscall", 6'h00, 6'h0C, F_SYS | 21'd5);
      lit("addi_x",  6'h08, 6'bx,  F_RW | F_ASRC | F_RS | 21'd5);
      lit("sw_x",    6'h2B, 6'bx,  F_ASRC | F_MW | F_RS | F_RT | 21'd5);
      lit("beq_x",   6'h04, 6'bx,  F_BR | F_RS | F_RT | 21'd6);
      lit("bne_x",   6'h05, 6'bx,  F_BR | F_BNE | F_RS | F_RT | 21'd6);
      lit("xori_x",  6'h0E, 6'bx,  F_RW | F_ASRC | F_RS | F_ZE | 21'd9);
      lit("j",       6'h02, 6'h00, F_JMP | 21'd5);
      lit("jal",     6'h03, 6'h00, F_JMP | F_JAL | F_RW | 21'd5);
      lit("bad_op",  6'h3F, 6'h00, 21'd5);
`ifdef CTRL_COP0_EN
      lit("cop0_f00", 6'h10, 6'h00, F_COP | 21'd5);
      lit("cop0_f18", 6'h10, 6'h18, F_COP | 21'd5);
`else
      lit("cop0_f00", 6'h10, 6'h00, 21'd5);
      lit("cop0_f18", 6'h10, 6'h18, 21'd5);
`endif

      for (int i = 0; i < 28; i++) begin
         logic [11:0] e;
         e = vecs[i];
         step(e[11:6], e[5:0]);
      end
      for (int i = 0; i < 40; i++) begin
         step(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end

      repeat (2) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
